// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register-file write port: round-robin grant among
// ALU/LSU/CSR, registered write port, and a per-register busy scoreboard.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,

  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,

  input  logic              csr_valid,
  input  logic [ADDR_W-1:0] csr_rd,
  input  logic [DATA_W-1:0] csr_data,
  output logic              csr_ready,

  output logic              wren,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] reg_data,

  input  logic              mark_valid,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  input  logic [ADDR_W-1:0] q_rd,
  output logic              stall
);

  localparam int NREG = 2 ** ADDR_W;

  // Requester index 0=ALU, 1=LSU, 2=CSR; ptr never leaves 0..2.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  logic [2:0]        valid;
  logic [2:0]        grant;
  logic [1:0]        sel;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              write_next;

  logic [1:0]        ptr_reg;
  logic [1:0]        ptr_next;
  logic              wren_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [DATA_W-1:0] reg_data_reg;
  logic [NREG-1:1]   busy_reg;
  logic [NREG-1:0]   busy;

  assign valid = {csr_valid, lsu_valid, alu_valid};

  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant = '0;
    sel   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      idx = wrap3({1'b0, ptr_reg} + 3'(i));
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        sel        = idx;
        found      = 1'b1;
      end
    end
  end

  assign alu_ready = grant[0];
  assign lsu_ready = grant[1];
  assign csr_ready = grant[2];

  // A grant is only ever issued to a valid requester, so any grant is a transfer.
  assign xfer = |grant;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    case (sel)
      2'd1: begin
        sel_rd   = lsu_rd;
        sel_data = lsu_data;
      end
      2'd2: begin
        sel_rd   = csr_rd;
        sel_data = csr_data;
      end
      default: ;
    endcase
  end

  assign write_next = xfer && (sel_rd != '0);
  assign ptr_next   = xfer ? wrap3({1'b0, sel} + 3'd1) : ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= 2'd0;
      wren_reg     <= 1'b0;
      rd_addr_reg  <= '0;
      reg_data_reg <= '0;
    end else begin
      ptr_reg  <= ptr_next;
      wren_reg <= write_next;
      if (write_next) begin
        rd_addr_reg  <= sel_rd;
        reg_data_reg <= sel_data;
      end
    end
  end

  assign wren     = wren_reg;
  assign rd_addr  = rd_addr_reg;
  assign reg_data = reg_data_reg;

  // Set has priority over clear: a newly issued producer owns the register.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_reg[gi] <= 1'b0;
        end else if (mark_valid && (mark_addr == ADDR_W'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (wren_reg && (rd_addr_reg == ADDR_W'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign busy  = {busy_reg, 1'b0};
  assign stall = busy[q_rs1] | busy[q_rs2] | busy[q_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table for grants and scoreboard
// traffic, write-port scoreboard queue, and a hand-written async-reset sequence.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, csr_valid;
  logic [4:0]  alu_rd, lsu_rd, csr_rd;
  logic [31:0] alu_data, lsu_data, csr_data;
  logic        alu_ready, lsu_ready, csr_ready;
  logic        wren;
  logic [4:0]  rd_addr;
  logic [31:0] reg_data;
  logic        mark_valid;
  logic [4:0]  mark_addr, q_rs1, q_rs2, q_rd;
  logic        stall;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .csr_valid(csr_valid), .csr_rd(csr_rd), .csr_data(csr_data), .csr_ready(csr_ready),
    .wren(wren), .rd_addr(rd_addr), .reg_data(reg_data),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .stall(stall)
  );

  typedef struct {
    logic [2:0]  v;    // {csr, lsu, alu} valid
    logic [4:0]  ra, rl, rc;
    logic [31:0] da, dl, dc;
    logic        mv;
    logic [4:0]  ma, q1, q2, qd;
    logic [2:0]  er;   // expected {csr, lsu, alu} ready
  } vec_t;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  vec_t        tbl[$];
  wr_t         sbq[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] mbusy = '0;
  logic        cur_w_en = 1'b0;
  logic [4:0]  cur_w_addr = '0;
  logic [4:0]  last_a = '0;
  logic [31:0] last_d = '0;

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] ra, input logic [4:0] rl,
                              input logic [4:0] rc, input logic mv, input logic [4:0] ma,
                              input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd,
                              input logic [2:0] er);
    vec_t t;
    t.v = v; t.ra = ra; t.rl = rl; t.rc = rc;
    t.da = {24'hA1A1A1, 3'b0, ra};
    t.dl = {24'hB2B2B2, 3'b0, rl};
    t.dc = {24'hC3C3C3, 3'b0, rc};
    t.mv = mv; t.ma = ma; t.q1 = q1; t.q2 = q2; t.qd = qd; t.er = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic exp_w;
    exp_w = (sbq.size() > 0) && (sbq[0].cyc == cyc);
    chk("wren", {31'b0, wren}, {31'b0, exp_w});
    if (exp_w) begin
      last_a = sbq[0].rd;
      last_d = sbq[0].d;
      void'(sbq.pop_front());
    end
    chk("rd_addr", {27'b0, rd_addr}, {27'b0, last_a});
    chk("reg_data", reg_data, last_d);
    chk("stall", {31'b0, stall}, {31'b0, mbusy[q_rs1] | mbusy[q_rs2] | mbusy[q_rd]});
    cur_w_en   = exp_w;
    cur_w_addr = last_a;
    $display("cyc %0d: wren=%0b rd_addr=%0d reg_data=%h stall=%0b", cyc, wren, rd_addr, reg_data, stall);
  endtask

  task automatic tick();
    logic [31:0] nb;
    nb = mbusy;
    if (cur_w_en) nb[cur_w_addr] = 1'b0;
    if (mark_valid && mark_addr != 5'd0) nb[mark_addr] = 1'b1;
    if (!rst_n) nb = '0;
    @(posedge clk);
    cyc++;
    mbusy = nb;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic apply(input vec_t t);
    logic [4:0]  r;
    logic [31:0] d;
    {csr_valid, lsu_valid, alu_valid} = t.v;
    alu_rd = t.ra; lsu_rd = t.rl; csr_rd = t.rc;
    alu_data = t.da; lsu_data = t.dl; csr_data = t.dc;
    mark_valid = t.mv; mark_addr = t.ma;
    q_rs1 = t.q1; q_rs2 = t.q2; q_rd = t.qd;
    #1;
    chk("ready", {29'b0, csr_ready, lsu_ready, alu_ready}, {29'b0, t.er});
    r = 5'd0;
    d = '0;
    if (t.er[0]) begin r = t.ra; d = t.da; end
    if (t.er[1]) begin r = t.rl; d = t.dl; end
    if (t.er[2]) begin r = t.rc; d = t.dc; end
    if (t.er != 3'b000 && r != 5'd0) sbq.push_back('{cyc + 1, r, d});
    tick();
  endtask

  initial begin
    vec_t t;
    rst_n = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b1; csr_valid = 1'b1;
    alu_rd = 5'd1; lsu_rd = 5'd2; csr_rd = 5'd3;
    alu_data = 32'h1; lsu_data = 32'h2; csr_data = 32'h3;
    mark_valid = 1'b0; mark_addr = '0; q_rs1 = '0; q_rs2 = '0; q_rd = '0;

    // Grant order, rd=0 handling, scoreboard set/clear and set-wins collision.
    // Args: valid, ra, rl, rc, mark_v, mark_a, q_rs1, q_rs2, q_rd, expected ready.
    tbl.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001));
    tbl.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b010));
    tbl.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001));
    tbl.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b010));
    tbl.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b100));
    t = mk(3'b010, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b010);
    t.dl = 32'hDEADBEEF;
    tbl.push_back(t);
    tbl.push_back(mk(3'b111, 5'd4, 5'd5, 5'd6, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk(3'b011, 5'd8, 5'd9, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001));
    tbl.push_back(mk(3'b001, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(3'b101, 5'd11, 5'd0, 5'd12, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk(3'b101, 5'd11, 5'd0, 5'd13, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 3'b001));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd7, 3'b000));
    tbl.push_back(mk(3'b001, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 3'b001));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd7, 3'b000));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 3'b000));
    tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 3'b000));

    // Reset held with every requester valid.
    #1;
    chk("rst_wren", {31'b0, wren}, 32'd0);
    chk("rst_rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("rst_reg_data", reg_data, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_ready", {29'b0, csr_ready, lsu_ready, alu_ready}, 32'b001);
    repeat (2) tick();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      $display("vec %0d: valid=%b ready=%b mark=%0b/%0d", i, tbl[i].v,
               {csr_ready, lsu_ready, alu_ready}, tbl[i].mv, tbl[i].ma);
    end

    // Async reset between edges while a write to busy x3 is pending.
    apply(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd0, 5'd0, 3'b000));
    apply(mk(3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 3'b001));
    alu_valid = 1'b0;
    #1;
    chk("pre_rst_stall", {31'b0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wren", {31'b0, wren}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("arst_reg_data", reg_data, 32'd0);
    sbq.delete();
    mbusy = '0;
    cur_w_en = 1'b0;
    last_a = '0;
    last_d = '0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // After release the pointer is back at ALU.
    apply(mk(3'b111, 5'd20, 5'd21, 5'd22, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b001));
    apply(mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000));
    tick();
    chk("sb_drain", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
